uart_tx_module: RTL and testbench

UART_TX_MODULE -- requirements
Module: uart_tx_module

---
 rtl/uart_tx_module.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_module.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_module.sv
// ----------------------------------------------------------------------------
// uart_tx_module
//
// Purpose:
//   UART transmitter with a small register-bus config register. Each byte is
//   sent as a start bit, eight data bits LSB first, an optional parity bit and
//   one or two stop bits. A bit lasts 16 pulses of the clk_16bd enable. The
//   config register is copied when a byte is accepted, so a write made during
//   a frame only affects the frames that follow it.
//
// Ports:
//   clk            system clock, the only clock in the block
//   rst            synchronous active-high reset
//   clk_16bd       1-cycle enable pulse at 16x the baud rate
//   tx_data        byte to send, sampled only when it is accepted
//   tx_valid       tx_data is offered for transmission
//   tx_ready       transmitter is idle and can accept a byte
//   Tx             serial line, idle high, driven from a register
//   busy           a frame is in progress (inverse of tx_ready)
//   address        register-bus address
//   data           register-bus write data (bit 3 is ignored)
//   valid          register-bus transaction strobe
//   ack            1-cycle pulse the cycle after an accepted write or read
//   data_out       read data, 4'h0 when no read response is active
//   data_out_valid read data valid
//
// Config register cfg[2:0]:
//   bit0 parity enable, bit1 odd parity (0 = even), bit2 two stop bits
// ----------------------------------------------------------------------------
module uart_tx_module #(
    parameter logic [3:0] CFG_ADDR = 4'hA,
    parameter logic [3:0] RD_ADDR  = 4'hB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_16bd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Tx,
    output logic       busy,
    input  logic [3:0] address,
    input  logic [3:0] data,
    input  logic       valid,
    output logic       ack,
    output logic [3:0] data_out,
    output logic       data_out_valid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] CFG_PAR_EN   = 3'd0;
    localparam logic [2:0] CFG_PAR_ODD  = 3'd1;
    localparam logic [2:0] CFG_TWO_STOP = 3'd2;

    logic [2:0] cfg;
    logic [2:0] cfg_snap;
    logic [2:0] state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic       second_stop;
    logic [7:0] data_q;
    logic       bit_end;
    logic       wr_hit;
    logic       rd_hit;

    // Only cfg[2:0] is architected; the top bus data bit is deliberately dropped.
    logic unused_data_msb;
    assign unused_data_msb = data[3];

    assign wr_hit = valid && (address == CFG_ADDR);
    assign rd_hit = valid && (address == RD_ADDR);

    // A bit ends on the pulse where the tick counter wraps from 15 to 0.
    assign bit_end = clk_16bd && (tick_cnt == 4'hF);

    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;

    // ------------------------------------------------------------------------
    // Register bus: config write, config read-back, registered ack.
    // Read data is forced to zero outside a response so it can be OR-combined
    // with other blocks on the same bus.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values; blocking = here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg            <= 3'b001;
            ack            <= 1'b0;
            data_out       <= 4'h0;
            data_out_valid <= 1'b0;
        end else begin
            ack            <= wr_hit || rd_hit;
            data_out       <= 4'h0;
            data_out_valid <= 1'b0;
            if (wr_hit) begin
                cfg <= data[2:0];
            end
            if (rd_hit) begin
                data_out       <= {1'b0, cfg};
                data_out_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM. Tx is a register so the line never glitches.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            Tx          <= 1'b1;
            tick_cnt    <= 4'h0;
            bit_idx     <= 3'd0;
            second_stop <= 1'b0;
            data_q      <= 8'h00;
            cfg_snap    <= 3'b000;
        end else begin
            // The tick counter only runs inside a frame, so a pulse on the
            // acceptance cycle is not counted toward the start bit.
            if (state != S_IDLE && clk_16bd) begin
                tick_cnt <= tick_cnt + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    Tx <= 1'b1;
                    if (tx_valid) begin
                        data_q      <= tx_data;
                        cfg_snap    <= cfg;
                        tick_cnt    <= 4'h0;
                        bit_idx     <= 3'd0;
                        second_stop <= 1'b0;
                        Tx          <= 1'b0;
                        state       <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        Tx    <= data_q[0];
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        // Index wraps back to 0 after bit 7.
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (cfg_snap[CFG_PAR_EN]) begin
                                Tx    <= (^data_q) ^ cfg_snap[CFG_PAR_ODD];
                                state <= S_PARITY;
                            end else begin
                                Tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            Tx <= data_q[bit_idx + 3'd1];
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        Tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        if (cfg_snap[CFG_TWO_STOP] && !second_stop) begin
                            second_stop <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    Tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_module
//
// Self-checking bench for uart_tx_module. The expected line waveform of every
// frame is built as a list of bit values (start, data LSB first, optional
// parity, stop bits) from the byte and the config in force when the byte is
// accepted; each clk_16bd pulse then selects list entry tick/16. clk_16bd is
// produced with random gaps. Inputs change on the falling edge and right after
// the rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_module;

    localparam logic [3:0] CFG_ADDR = 4'hA;
    localparam logic [3:0] RD_ADDR  = 4'hB;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_16bd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       Tx;
    logic       busy;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;
    logic [3:0] data_out;
    logic       data_out_valid;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] model_cfg;

    uart_tx_module #(
        .CFG_ADDR(CFG_ADDR),
        .RD_ADDR (RD_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_16bd      (clk_16bd),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .Tx            (Tx),
        .busy          (busy),
        .address       (address),
        .data          (data),
        .valid         (valid),
        .ack           (ack),
        .data_out      (data_out),
        .data_out_valid(data_out_valid)
    );

    always #5 clk = ~clk;

    // Baud-tick source: single-cycle pulses separated by 1..3 idle cycles.
    initial begin
        int gap;
        gap      = 0;
        clk_16bd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gap == 0) begin
                clk_16bd = 1'b1;
                gap      = $urandom_range(1, 3);
            end else begin
                clk_16bd = 1'b0;
                gap--;
            end
        end
    end

    // Sends one byte (called on a falling edge) and checks the line tick by
    // tick. hold keeps tx_valid high and presents next_d after acceptance;
    // mid_wr performs a config write part-way through the frame.
    task automatic run_frame(input logic [7:0] d, input string name, input bit hold,
                             input logic [7:0] next_d, input bit mid_wr,
                             input logic [3:0] mid_val);
        bit         q[$];
        logic [2:0] c;
        int         n, total, k, cyc;
        n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: tx_ready=%b required 1", name, tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        c        = model_cfg;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (c[0]) q.push_back((($countones(d) % 2) == 1) ^ c[1]);
        q.push_back(1'b1);
        if (c[2]) q.push_back(1'b1);
        total = q.size() * 16;

        @(negedge clk);
        if (hold) begin
            tx_data = next_d;
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
        checks++;
        if (Tx !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s start: Tx=%b busy=%b tx_ready=%b required 0/1/0",
                     name, Tx, busy, tx_ready);
        end

        k   = 0;
        cyc = 0;
        while (k < total && cyc < total * 6) begin
            if (mid_wr) begin
                if (cyc == 30) begin
                    valid   = 1'b1;
                    address = CFG_ADDR;
                    data    = mid_val;
                end else if (cyc == 31) begin
                    valid     = 1'b0;
                    model_cfg = mid_val[2:0];
                end
            end
            if (clk_16bd) begin
                checks++;
                if (Tx !== q[k/16] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s tick %0d (bit %0d): Tx=%b busy=%b required Tx=%b busy=1",
                             name, k, k / 16, Tx, busy, q[k/16]);
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (k != total) begin
            errors++;
            $display("FAIL %s tick_budget: saw %0d ticks required %0d", name, k, total);
        end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || Tx !== 1'b1) begin
            errors++;
            $display("FAIL %s end: tx_ready=%b busy=%b Tx=%b required 1/0/1 after %0d ticks",
                     name, tx_ready, busy, Tx, total);
        end
    endtask

    // Bus write at address a; checks ack timing and idle read-data outputs.
    task automatic bus_write(input logic [3:0] a, input logic [3:0] d, input string name);
        logic exp_ack;
        exp_ack = (a == CFG_ADDR) || (a == RD_ADDR);
        address = a;
        data    = d;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        if (a == CFG_ADDR) model_cfg = d[2:0];
        checks++;
        if (ack !== exp_ack || (a != RD_ADDR && (data_out !== 4'h0 || data_out_valid !== 1'b0))) begin
            errors++;
            $display("FAIL %s wr_resp: ack=%b data_out=%h dov=%b required ack=%b", name, ack,
                     data_out, data_out_valid, exp_ack);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || data_out !== 4'h0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_after: ack=%b data_out=%h dov=%b required 0/0/0", name, ack,
                     data_out, data_out_valid);
        end
    endtask

    // Bus read at address a; a hit returns the modelled config register.
    task automatic bus_read(input logic [3:0] a, input string name);
        logic [3:0] exp_do;
        logic       exp_v;
        exp_v   = (a == RD_ADDR);
        exp_do  = exp_v ? {1'b0, model_cfg} : 4'h0;
        address = a;
        data    = 4'($urandom);
        valid   = 1'b1;
        if (a == CFG_ADDR) model_cfg = data[2:0];
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (data_out !== exp_do || data_out_valid !== exp_v ||
            ack !== (exp_v || a == CFG_ADDR)) begin
            errors++;
            $display("FAIL %s rd_resp: data_out=%h dov=%b ack=%b required %h/%b", name,
                     data_out, data_out_valid, ack, exp_do, exp_v);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || data_out !== 4'h0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_after: ack=%b data_out=%h dov=%b required 0/0/0", name, ack,
                     data_out, data_out_valid);
        end
    endtask

    task automatic test_reset();
        // Reset with competing tx_valid and bus write: reset must win.
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        valid    = 1'b1;
        address  = CFG_ADDR;
        data     = 4'h6;
        repeat (3) @(negedge clk);
        checks++;
        if (Tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || ack !== 1'b0 ||
            data_out !== 4'h0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: Tx=%b rdy=%b busy=%b ack=%b do=%h dov=%b required 1/1/0/0/0/0",
                     Tx, tx_ready, busy, ack, data_out, data_out_valid);
        end
        rst       = 1'b0;
        tx_valid  = 1'b0;
        valid     = 1'b0;
        model_cfg = 3'b001;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || Tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: tx_ready=%b Tx=%b required 1/1", tx_ready, Tx);
        end
        bus_read(RD_ADDR, "reset_cfg");
    endtask

    task automatic test_basic();
        run_frame(8'h55, "even_0x55", 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic test_odd_parity();
        bus_write(CFG_ADDR, 4'b0011, "odd_wr");
        bus_read(RD_ADDR, "odd_rd");
        run_frame(8'h00, "odd_0x00", 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic test_two_stop();
        bus_write(CFG_ADDR, 4'b1100, "msb_ignored_wr");
        bus_read(RD_ADDR, "msb_ignored_rd");
        bus_write(CFG_ADDR, 4'b0100, "two_stop_wr");
        run_frame(8'hA5, "two_stop_0xA5", 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic test_reset_mid_frame();
        int k, cyc;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        k   = 0;
        cyc = 0;
        // Stop in the middle of data bit 3 (line bit 4).
        while (k < 16 * 4 + 8 && cyc < 2000) begin
            if (clk_16bd) k++;
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        model_cfg = 3'b001;
        checks++;
        if (Tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: Tx=%b tx_ready=%b busy=%b required 1/1/0", Tx, tx_ready, busy);
        end
        run_frame(8'h0F, "after_reset_0x0F", 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic test_back_to_back();
        run_frame(8'h12, "b2b_0x12", 1'b1, 8'h34, 1'b1, 4'b0000);
        run_frame(8'h34, "b2b_0x34", 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic test_bad_addr();
        bus_write(4'h0, 4'h7, "bad_addr_wr");
        bus_read(4'h0, "bad_addr_rd");
        bus_read(RD_ADDR, "cfg_unchanged");
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            c = 4'($urandom);
            d = 8'($urandom);
            bus_write(CFG_ADDR, c, "rand_wr");
            run_frame(d, $sformatf("rand%0d_cfg%h_d%h", i, c, d), 1'b0, 8'h00, 1'b0, 4'h0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        address   = 4'h0;
        data      = 4'h0;
        valid     = 1'b0;
        model_cfg = 3'b001;
        @(negedge clk);
        test_reset();
        test_basic();
        test_odd_parity();
        test_two_stop();
        test_reset_mid_frame();
        test_back_to_back();
        test_bad_addr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
